// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types and widths used by the flush unit
package core_pkg;

  localparam int XLEN      = 32;
  localparam int ROB_IDX_W = 6;

  typedef enum logic {
    FLUSH_MISPREDICT = 1'b0,
    FLUSH_EXCEPTION  = 1'b1
  } flush_cause_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SQUASH   = 3'd1,
    ST_RESTORE  = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_REDIRECT = 3'd4,
    ST_DONE     = 3'd5
  } flush_state_t;

  // Exceptions always restart at the trap vector; mispredicts at the ROB-supplied target.
  function automatic logic [XLEN-1:0] select_redirect_pc(
    input flush_cause_t    cause,
    input logic [XLEN-1:0] target_pc,
    input logic [XLEN-1:0] trap_vector
  );
    return (cause == FLUSH_EXCEPTION) ? trap_vector : target_pc;
  endfunction

endpackage

// File: rtl/flush_stat_counter.sv
// rtl/flush_stat_counter.sv - 32-bit saturating event counter
module flush_stat_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Advance on inc, sticking at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/flush_unit.sv
// rtl/flush_unit.sv - ROB flush responder: squash, RAT restore, drain, redirect, done (FLUSH_UNIT_STATS_EN adds counters)
module flush_unit
  import core_pkg::*;
#(
  parameter int              FLUSH_CYCLES = 2,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              ROB_IDX_W    = core_pkg::ROB_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rob_flush_valid,
  output logic                 rob_flush_ready,
  input  flush_cause_t         rob_flush_cause,
  input  logic [XLEN-1:0]      rob_flush_pc,
  input  logic [ROB_IDX_W-1:0] rob_flush_idx,
  output logic                 rob_flush_done,
  output logic                 pipe_flush,
  output logic                 rat_restore,
  input  logic                 backend_idle,
  output logic                 fetch_redirect_valid,
  input  logic                 fetch_redirect_ready,
  output logic [XLEN-1:0]      fetch_redirect_pc
`ifdef FLUSH_UNIT_STATS_EN
  ,
  output logic [31:0]          stat_flush_count,
  output logic [31:0]          stat_busy_cycles
`endif
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  flush_state_t         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  flush_cause_t         cause_q, cause_d;
  logic [ROB_IDX_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0]      pc_q, pc_d;

  // Cause and index are held for the duration of a flush for debug visibility only.
  logic ctx_unused;
  assign ctx_unused = ^{cause_q, idx_q};

  // Next-state and Moore outputs of the recovery sequence.
  always_comb begin
    state_d              = state_q;
    cnt_d                = cnt_q;
    cause_d              = cause_q;
    idx_d                = idx_q;
    pc_d                 = pc_q;
    rob_flush_ready      = 1'b0;
    pipe_flush           = 1'b0;
    rat_restore          = 1'b0;
    fetch_redirect_valid = 1'b0;
    rob_flush_done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rob_flush_ready = 1'b1;
        if (rob_flush_valid) begin
          cause_d = rob_flush_cause;
          idx_d   = rob_flush_idx;
          pc_d    = select_redirect_pc(rob_flush_cause, rob_flush_pc, TRAP_VECTOR);
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          state_d = ST_SQUASH;
        end
      end
      ST_SQUASH: begin
        pipe_flush = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_RESTORE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESTORE: begin
        rat_restore = 1'b1;
        state_d     = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (backend_idle) begin
          state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        fetch_redirect_valid = 1'b1;
        if (fetch_redirect_ready) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        rob_flush_done = 1'b1;
        state_d        = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched request registers; reset abandons any flush without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cause_q <= FLUSH_MISPREDICT;
      idx_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      idx_q   <= idx_d;
      pc_q    <= pc_d;
    end
  end

  assign fetch_redirect_pc = pc_q;

`ifdef FLUSH_UNIT_STATS_EN
  logic accept;
  logic busy;
  assign accept = rob_flush_valid && (state_q == ST_IDLE);
  assign busy   = (state_q != ST_IDLE);

  flush_stat_counter u_flush_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .count (stat_flush_count)
  );

  flush_stat_counter u_busy_cycles (
    .clk   (clk),
    .rst   (rst),
    .inc   (busy),
    .count (stat_busy_cycles)
  );
`endif

endmodule

// File: tb/tb_flush_unit.sv
// tb/tb_flush_unit.sv - directed scoreboard bench for flush_unit
module tb_flush_unit;
  import core_pkg::*;

  localparam logic [31:0] TRAP = 32'h0000_0100;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 rob_flush_valid = 1'b0;
  logic                 rob_flush_ready;
  flush_cause_t         rob_flush_cause = FLUSH_MISPREDICT;
  logic [XLEN-1:0]      rob_flush_pc = '0;
  logic [ROB_IDX_W-1:0] rob_flush_idx = '0;
  logic                 rob_flush_done;
  logic                 pipe_flush;
  logic                 rat_restore;
  logic                 backend_idle = 1'b1;
  logic                 fetch_redirect_valid;
  logic                 fetch_redirect_ready = 1'b1;
  logic [XLEN-1:0]      fetch_redirect_pc;
`ifdef FLUSH_UNIT_STATS_EN
  logic [31:0]          stat_flush_count;
  logic [31:0]          stat_busy_cycles;
`endif

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];
  logic prev_wait = 1'b0;

  flush_unit #(.FLUSH_CYCLES(2), .TRAP_VECTOR(TRAP), .ROB_IDX_W(ROB_IDX_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .rob_flush_valid      (rob_flush_valid),
    .rob_flush_ready      (rob_flush_ready),
    .rob_flush_cause      (rob_flush_cause),
    .rob_flush_pc         (rob_flush_pc),
    .rob_flush_idx        (rob_flush_idx),
    .rob_flush_done       (rob_flush_done),
    .pipe_flush           (pipe_flush),
    .rat_restore          (rat_restore),
    .backend_idle         (backend_idle),
    .fetch_redirect_valid (fetch_redirect_valid),
    .fetch_redirect_ready (fetch_redirect_ready),
    .fetch_redirect_pc    (fetch_redirect_pc)
`ifdef FLUSH_UNIT_STATS_EN
    ,
    .stat_flush_count     (stat_flush_count),
    .stat_busy_cycles     (stat_busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request while IDLE; returns one cycle after acceptance (first SQUASH cycle).
  task automatic send(input flush_cause_t c, input logic [31:0] pc, input logic [ROB_IDX_W-1:0] idx);
    rob_flush_valid = 1'b1;
    rob_flush_cause = c;
    rob_flush_pc    = pc;
    rob_flush_idx   = idx;
    chk1("accept_ready", rob_flush_ready, 1'b1);
    exp_q.push_back((c == FLUSH_EXCEPTION) ? TRAP : pc);
    step();
    rob_flush_valid = 1'b0;
  endtask

  task automatic run_to_done();
    int n = 0;
    while (!rob_flush_done && n < 50) begin
      step();
      n++;
    end
    chk1("done_seen", rob_flush_done, 1'b1);
    step();
  endtask

  // Scoreboard consumer: redirect handshakes pop the expected PC; also tracks done pulses
  // and that a pending redirect is never withdrawn.
  always @(negedge clk) begin
    if (rst) begin
      prev_wait = 1'b0;
    end else begin
      if (rob_flush_done) done_cnt++;
      if (prev_wait) chk1("redir_valid_held", fetch_redirect_valid, 1'b1);
      if (fetch_redirect_valid && fetch_redirect_ready) begin
        if (exp_q.size() == 0) begin
          chk1("redir_unexpected", 1'b1, 1'b0);
        end else begin
          chk32("redir_pc", fetch_redirect_pc, exp_q.pop_front());
        end
      end
      prev_wait = fetch_redirect_valid && !fetch_redirect_ready;
    end
  end

  initial begin
    logic exp_pf[6];
    logic exp_rat[6];
    logic exp_rv[6];
    logic exp_done[6];
    exp_pf   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_rat  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_rv   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    step();
    step();
    rst = 1'b0;
    chk1("rst_ready", rob_flush_ready, 1'b1);
    chk1("rst_pipe_flush", pipe_flush, 1'b0);
    chk1("rst_rat", rat_restore, 1'b0);
    chk1("rst_redir_valid", fetch_redirect_valid, 1'b0);
    chk1("rst_done", rob_flush_done, 1'b0);
    chk32("rst_redir_pc", fetch_redirect_pc, 32'h0);

    // 1: mispredict, minimum latency cycle-by-cycle
    send(FLUSH_MISPREDICT, 32'h2000, 6'd3);
    for (int k = 0; k < 6; k++) begin
      chk1($sformatf("t1_pf_%0d", k + 1), pipe_flush, exp_pf[k]);
      chk1($sformatf("t1_rat_%0d", k + 1), rat_restore, exp_rat[k]);
      chk1($sformatf("t1_rv_%0d", k + 1), fetch_redirect_valid, exp_rv[k]);
      chk1($sformatf("t1_done_%0d", k + 1), rob_flush_done, exp_done[k]);
      chk1($sformatf("t1_ready_%0d", k + 1), rob_flush_ready, 1'b0);
      if (k == 4) chk32("t1_pc", fetch_redirect_pc, 32'h2000);
      step();
    end
    chk1("t1_ready_after", rob_flush_ready, 1'b1);

    // 2: exception uses trap vector, index latched
    send(FLUSH_EXCEPTION, 32'h2000, 6'd5);
    chk32("t2_idx", 32'(dut.idx_q), 32'd5);
    run_to_done();
    chk32("t2_idx_held", 32'(dut.idx_q), 32'd5);

    // 3: backend busy for 5 DRAIN cycles
    backend_idle = 1'b0;
    send(FLUSH_MISPREDICT, 32'h3000, 6'd7);
    step(); step(); step();
    for (int k = 0; k < 5; k++) begin
      chk1($sformatf("t3_rv_busy_%0d", k), fetch_redirect_valid, 1'b0);
      step();
    end
    chk1("t3_rv_before_idle", fetch_redirect_valid, 1'b0);
    backend_idle = 1'b1;
    step();
    chk1("t3_rv_after_idle", fetch_redirect_valid, 1'b1);
    run_to_done();

    // 4: fetch stalls the redirect for 3 cycles
    fetch_redirect_ready = 1'b0;
    send(FLUSH_MISPREDICT, 32'h3000, 6'd8);
    step(); step(); step(); step();
    for (int k = 0; k < 3; k++) begin
      chk1($sformatf("t4_rv_%0d", k), fetch_redirect_valid, 1'b1);
      chk32($sformatf("t4_pc_%0d", k), fetch_redirect_pc, 32'h3000);
      chk1($sformatf("t4_nodone_%0d", k), rob_flush_done, 1'b0);
      step();
    end
    fetch_redirect_ready = 1'b1;
    chk1("t4_rv_hs", fetch_redirect_valid, 1'b1);
    step();
    chk1("t4_done", rob_flush_done, 1'b1);
    step();

    // 5: second request held during a flush is taken only after DONE
    send(FLUSH_MISPREDICT, 32'h4000, 6'd1);
    rob_flush_valid = 1'b1;
    rob_flush_pc    = 32'h5000;
    rob_flush_idx   = 6'd9;
    for (int k = 1; k <= 6; k++) begin
      chk1($sformatf("t5_ready_%0d", k), rob_flush_ready, 1'b0);
      chk1($sformatf("t5_done_%0d", k), rob_flush_done, (k == 6));
      step();
    end
    chk1("t5_reaccept_ready", rob_flush_ready, 1'b1);
    exp_q.push_back(32'h5000);
    step();
    rob_flush_valid = 1'b0;
    chk1("t5_second_squash", pipe_flush, 1'b1);
    chk32("t5_second_idx", 32'(dut.idx_q), 32'd9);
    run_to_done();

    // 6: reset while waiting in REDIRECT
    fetch_redirect_ready = 1'b0;
    send(FLUSH_MISPREDICT, 32'h6000, 6'd2);
    step(); step(); step(); step();
    chk1("t6_in_redirect", fetch_redirect_valid, 1'b1);
    rst = 1'b1;
    step();
    chk1("t6_ready", rob_flush_ready, 1'b1);
    chk1("t6_pf", pipe_flush, 1'b0);
    chk1("t6_rat", rat_restore, 1'b0);
    chk1("t6_rv", fetch_redirect_valid, 1'b0);
    chk1("t6_done", rob_flush_done, 1'b0);
    chk32("t6_pc", fetch_redirect_pc, 32'h0);
    exp_q.delete();
    rst = 1'b0;
    fetch_redirect_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk1($sformatf("t6_nodone_%0d", k), rob_flush_done, 1'b0);
      step();
    end

    // Three back-to-back flushes from a clean reset
    send(FLUSH_MISPREDICT, 32'h7000, 6'd4);
    run_to_done();
    send(FLUSH_EXCEPTION, 32'h7004, 6'd5);
    run_to_done();
    send(FLUSH_MISPREDICT, 32'h7008, 6'd6);
    run_to_done();
`ifdef FLUSH_UNIT_STATS_EN
    chk32("stat_flush_count", stat_flush_count, 32'd3);
    chk32("stat_busy_cycles", stat_busy_cycles, 32'd18);
`endif

    step();
    chk32("done_pulses", 32'(done_cnt), 32'd9);
    chk32("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
